// File: rtl/mult_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } mult_state_t;

    localparam int unsigned MULT_W_DEFAULT = 5;
    localparam int unsigned MULT_CNT_W     = $clog2(MULT_W_DEFAULT);

    // Two's-complement negation on a 64-bit carrier; callers cast the
    // result down to their 2W-bit product width (valid for W <= 32).
    function automatic logic [63:0] negate_2w(input logic [63:0] x);
        return ~x + 64'd1;
    endfunction

endpackage

// File: rtl/mult_seq_cond_negate.sv
// Combinational conditional negation, used to form operand magnitudes.
module cond_negate
    import mult_pkg::*;
#(
    parameter int unsigned N = 5
) (
    input  logic         neg,
    input  logic [N-1:0] operand,
    output logic [N-1:0] magnitude
);

    // Negate when requested; -2^(N-1) maps onto 2^(N-1) as an unsigned value.
    always_comb begin
        magnitude = neg ? (~operand + {{(N-1){1'b0}}, 1'b1}) : operand;
    end

endmodule

// File: rtl/mult_seq.sv
// Iterative shift-add multiplier with unsigned/signed modes and start/done.
module mult_seq
    import mult_pkg::*;
#(
    parameter int unsigned W = MULT_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic [2*W-1:0] RESULT,
    output logic           busy,
    output logic           done
);

    localparam int unsigned CNT_W = $clog2(W);

    mult_state_t      state;
    mult_state_t      state_next;

    logic [W-1:0]     mag_a;
    logic [W-1:0]     mag_b;
    logic             neg;
    logic [2*W-1:0]   acc;
    logic [2*W-1:0]   acc_step;
    logic [W:0]       upper_sum;
    logic [CNT_W-1:0] cnt;
    logic             last_iter;

    logic [W-1:0]     a_mag_in;
    logic [W-1:0]     b_mag_in;

    cond_negate #(.N(W)) u_neg_a (
        .neg       (signed_mode & A[W-1]),
        .operand   (A),
        .magnitude (a_mag_in)
    );

    cond_negate #(.N(W)) u_neg_b (
        .neg       (signed_mode & B[W-1]),
        .operand   (B),
        .magnitude (b_mag_in)
    );

    // State register; enable gates every transition, reset wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (enable) begin
            state <= state_next;
        end
    end

    // Next-state selection and the busy flag.
    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        last_iter  = (cnt == CNT_W'(W - 1));
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_iter) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One shift-add step: conditional add into the upper half keeping the
    // carry, then the carry becomes the new MSB as the whole word shifts right.
    always_comb begin
        upper_sum = {1'b0, acc[2*W-1:W]} + (mag_b[0] ? {1'b0, mag_a} : '0);
        acc_step  = {upper_sum, acc[W-1:1]};
    end

    // Datapath registers: operand capture, iteration, and result/done update.
    always_ff @(posedge clk) begin
        if (rst) begin
            mag_a  <= '0;
            mag_b  <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            RESULT <= '0;
            done   <= 1'b0;
        end else if (enable) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mag_a <= a_mag_in;
                        mag_b <= b_mag_in;
                        neg   <= signed_mode & (A[W-1] ^ B[W-1]);
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc_step;
                    mag_b <= mag_b >> 1;
                    cnt   <= cnt + 1'b1;
                end
                FIX: begin
                    RESULT <= neg ? (2*W)'(negate_2w(64'(acc))) : acc;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq.sv
// Directed self-checking bench for mult_seq at W=5.
module tb_mult_seq;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       start;
    logic       signed_mode;
    logic [4:0] A;
    logic [4:0] B;
    logic [9:0] RESULT;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    mult_seq #(.W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .start       (start),
        .signed_mode (signed_mode),
        .A           (A),
        .B           (B),
        .RESULT      (RESULT),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] a;
        logic [4:0] b;
        logic       sm;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one edge; returns just after that edge.
    task automatic start_op(input logic [4:0] a, input logic [4:0] b, input logic sm);
        A           = a;
        B           = b;
        signed_mode = sm;
        start       = 1'b1;
        tick();
        start = 1'b0;
        A     = '0;
        B     = '0;
    endtask

    // Count edges until done, and cycles with busy high, from the start edge.
    task automatic wait_done(input int max_edges, output int lat, output int busy_cyc);
        bit got;
        got      = 0;
        lat      = 0;
        busy_cyc = busy ? 1 : 0;
        for (int i = 0; i < max_edges; i++) begin
            tick();
            lat++;
            if (done) begin
                got = 1;
                check("busy_with_done", {31'd0, busy}, 32'd0);
                break;
            end
            if (busy) busy_cyc++;
        end
        if (!got) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat;
        int bc;
        int dcount;
        bit held;

        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        enable      = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        A           = '0;
        B           = '0;

        vecs[0]  = '{5'h07, 5'h1D, 1'b1, 10'h3EB};
        vecs[1]  = '{5'h10, 5'h10, 1'b1, 10'h100};
        vecs[2]  = '{5'h10, 5'h10, 1'b0, 10'h100};
        vecs[3]  = '{5'h10, 5'h01, 1'b1, 10'h3F0};
        vecs[4]  = '{5'h1F, 5'h1F, 1'b0, 10'h3C1};
        vecs[5]  = '{5'h1F, 5'h1F, 1'b1, 10'h001};
        vecs[6]  = '{5'h00, 5'h1F, 1'b0, 10'h000};
        vecs[7]  = '{5'h03, 5'h04, 1'b0, 10'h00C};
        vecs[8]  = '{5'h0F, 5'h0F, 1'b1, 10'h0E1};
        vecs[9]  = '{5'h0F, 5'h10, 1'b1, 10'h310};
        vecs[10] = '{5'h1D, 5'h1D, 1'b0, 10'h349};
        vecs[11] = '{5'h1D, 5'h05, 1'b1, 10'h3F1};
        vecs[12] = '{5'h1D, 5'h05, 1'b0, 10'h091};

        repeat (3) tick();
        rst = 1'b0;
        check("reset_result", {22'd0, RESULT}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        tick();

        // Table-driven products with latency and busy-window checks.
        for (int i = 0; i < 13; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].sm);
            wait_done(30, lat, bc);
            check($sformatf("vec%0d_result", i), {22'd0, RESULT}, {22'd0, vecs[i].exp});
            check($sformatf("vec%0d_latency", i), lat, 32'd6);
            check($sformatf("vec%0d_busy_cycles", i), bc, 32'd6);
            tick();
            check($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
        end

        // start while busy is ignored; back-to-back start in the done cycle.
        start_op(5'h03, 5'h04, 1'b0);
        tick();
        tick();
        A     = 5'h05;
        B     = 5'h05;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(30, lat, bc);
        check("busy_ignore_result", {22'd0, RESULT}, 32'h00C);
        check("busy_ignore_latency", lat + 3, 32'd6);
        start_op(5'h05, 5'h05, 1'b0);
        check("b2b_done_cleared", {31'd0, done}, 32'd0);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done(30, lat, bc);
        check("b2b_result", {22'd0, RESULT}, 32'h019);
        check("b2b_latency", lat, 32'd6);
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) dcount++;
        end
        check("no_extra_done", dcount, 32'd0);

        // Enable low for three edges in RUN stretches latency by three.
        start_op(5'h07, 5'h1D, 1'b1);
        tick();
        tick();
        enable = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
        wait_done(30, lat, bc);
        check("stall_result", {22'd0, RESULT}, 32'h3EB);
        check("stall_latency", lat + 5, 32'd9);
        // Pending done holds across a low-enable window.
        enable = 1'b0;
        held   = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (!done) held = 0;
        end
        check("done_stretched", {31'd0, held}, 32'd1);
        enable = 1'b1;
        tick();
        check("done_released", {31'd0, done}, 32'd0);

        // Reset mid-RUN aborts; a later operation still completes.
        start_op(5'h07, 5'h1D, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", {22'd0, RESULT}, 32'd0);
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || busy) dcount++;
        end
        check("abort_no_done", dcount, 32'd0);
        start_op(5'h03, 5'h04, 1'b0);
        wait_done(30, lat, bc);
        check("post_abort_result", {22'd0, RESULT}, 32'h00C);
        check("post_abort_latency", lat, 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
